// File: rtl/store_narrower.sv
// Store path narrower: turns one SB/SH/SW request into one or two beats on a
// 16-bit little-endian write bus, with registered outputs and valid/ready.
//
// state | meaning
// IDLE  | ready for a request; misaligned/done pulses are driven from here
// BEAT0 | first (or only) beat presented, waiting for mem_ready
// BEAT1 | upper halfword of a word store presented, waiting for mem_ready
module store_narrower #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    output logic              done,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic        accept, bad, beat_hs;
    logic        is_word;
    logic [15:0] data_hi;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign beat_hs   = mem_valid && mem_ready;

    always_comb begin
        bad = 1'b0;
        case (req_size)
            2'b01:   bad = req_addr[0];
            2'b10:   bad = (req_addr[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !bad) state_nx = BEAT0;
            BEAT0:   if (beat_hs) state_nx = is_word ? BEAT1 : IDLE;
            BEAT1:   if (beat_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // mem_valid tracks the registered state so it can only fall on a handshake or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            is_word    <= 1'b0;
            data_hi    <= '0;
        end else begin
            mem_valid  <= (state_nx != IDLE);
            done       <= beat_hs && ((state == BEAT1) || ((state == BEAT0) && !is_word));
            misaligned <= accept && bad;
            if (accept && !bad) begin
                is_word <= (req_size == 2'b10);
                data_hi <= req_data[31:16];
                if (req_size == 2'b00) begin
                    mem_addr  <= {req_addr[ADDR_W-1:1], 1'b0};
                    mem_wdata <= {req_data[7:0], req_data[7:0]};
                    mem_be    <= req_addr[0] ? 2'b10 : 2'b01;
                end else begin
                    mem_addr  <= req_addr;
                    mem_wdata <= req_data[15:0];
                    mem_be    <= 2'b11;
                end
            end else if ((state == BEAT0) && beat_hs && is_word) begin
                mem_addr  <= mem_addr + ADDR_W'(2);
                mem_wdata <= data_hi;
            end
        end
    end

endmodule

// File: tb/tb_store_narrower.sv
// Randomized scoreboard bench for store_narrower: a reference model queues the
// expected bus beats per accepted request and a monitor checks every cycle.
module tb_store_narrower;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        done;
    logic        misaligned;

    store_narrower #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        bit          last;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    bit    exp_done = 0;
    bit    exp_mis = 0;
    bit    mon_en = 0;
    bit    manual = 0;
    bit    always1 = 1;
    int    low_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what an accepted request must produce on the bus.
    initial forever begin
        @(negedge clk);
        #2;
        if (req_valid && req_ready) begin
            case (req_size)
                2'b00: q.push_back('{req_addr & 32'hFFFF_FFFE,
                                     {req_data[7:0], req_data[7:0]},
                                     req_addr[0] ? 2'b10 : 2'b01, 1'b1});
                2'b01: if (req_addr % 2 != 0) exp_mis = 1;
                       else q.push_back('{req_addr, req_data[15:0], 2'b11, 1'b1});
                2'b10: if (req_addr % 4 != 0) exp_mis = 1;
                       else begin
                           q.push_back('{req_addr, req_data[15:0], 2'b11, 1'b0});
                           q.push_back('{req_addr + 32'd2, req_data[31:16], 2'b11, 1'b1});
                       end
                default: exp_mis = 1;
            endcase
        end
    end

    // Monitor: sampled mid-cycle, compares DUT against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, q.size() == 0});
            chk("mem_valid", {31'd0, mem_valid}, {31'd0, q.size() != 0});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
            exp_mis  = 0;
            exp_done = 0;
            if (mem_valid && q.size() != 0) begin
                chk("mem_addr", mem_addr, q[0].addr);
                chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, q[0].wdata});
                chk("mem_be", {30'd0, mem_be}, {30'd0, q[0].be});
                if (mem_ready) begin
                    exp_done = q[0].last;
                    void'(q.pop_front());
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!manual) begin
            if (low_cnt > 0) begin
                mem_ready = 1'b0;
                low_cnt--;
            end else begin
                mem_ready = always1 ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_size = sz; req_addr = a; req_data = d;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept at %0t", $time);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_data  = $urandom;
    endtask

    initial begin
        #1;
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_mem_be", {30'd0, mem_be}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1;

        send(2'b00, 32'h0000_1003, 32'hAABB_CCDD);
        repeat (2) @(posedge clk);
        low_cnt = 4;
        send(2'b01, 32'h0000_2002, 32'h1234_5678);
        repeat (5) @(posedge clk);
        send(2'b10, 32'h0000_3000, 32'hCAFE_BABE);
        repeat (3) @(posedge clk);
        send(2'b10, 32'h0000_3002, 32'h1111_2222);
        send(2'b01, 32'h0000_0001, 32'h3333_4444);
        send(2'b11, 32'h0000_0000, 32'h5555_6666);
        repeat (2) @(posedge clk);
        send(2'b10, 32'hFFFF_FFFC, 32'h0BAD_F00D);
        repeat (3) @(posedge clk);
        send(2'b10, 32'hFFFF_FFFE, 32'h7777_8888);
        repeat (2) @(posedge clk);

        // Reset while the upper beat of a word store is stalled.
        @(posedge clk);
        #1;
        manual = 1;
        mem_ready = 1'b1;
        send(2'b10, 32'h0000_4000, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 0;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        q.delete();
        exp_done = 0;
        exp_mis  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        manual = 0;
        mon_en = 1;
        send(2'b00, 32'h0000_5000, 32'h0000_00A5);
        repeat (3) @(posedge clk);

        always1 = 0;
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (sz != 2'b00 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            send(sz, a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        always1 = 1;
        repeat (20) @(posedge clk);
        chk("drain", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
MEM-stage store path block; the write-side counterpart of the load-path sign/zero extension. It accepts one SB/SH/SW store request with a 32-bit register operand and narrows it onto a 16-bit little-endian data-memory write bus. Byte and halfword stores take one bus beat; word stores take two. Registered outputs and a valid/ready handshake let the pipeline stall on memory backpressure.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_addr

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  block can accept a request this cycle
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_addr  input  ADDR_W  byte address of store
req_data  input  32  register operand (rt)
mem_valid  output  1  write beat valid
mem_ready  input  1  memory accepts beat
mem_addr  output  ADDR_W  halfword-aligned beat address, bit 0 always 0
mem_wdata  output  16  beat write data
mem_be  output  2  byte enables; bit0 = low lane (even address), bit1 = high lane
done  output  1  one-cycle pulse: store fully written
misaligned  output  1  one-cycle pulse: request rejected, no bus activity

Behaviour:
- Async reset: state IDLE; mem_valid, done, misaligned = 0; mem_addr, mem_wdata, mem_be = 0. req_ready = 0 while rst is high.
- States: IDLE, BEAT0, BEAT1.
- req_ready = (state == IDLE) && !rst. A request is accepted on a rising edge with req_valid && req_ready. req_* are sampled only at acceptance; later changes are ignored.
- Alignment check at acceptance:
  - Halfword requires addr[0] = 0.
  - Word requires addr[1:0] = 00.
  - Size 11 is always an error.
  - On error: stay IDLE, misaligned = 1 for the next cycle only, no mem_valid, no done.
- Valid request: next state BEAT0; mem_valid = 1 in the cycle after acceptance. Latency from acceptance to first beat is 1 cycle.
- Byte store:
  - mem_addr = {addr[ADDR_W-1:1], 0}
  - mem_wdata = {data[7:0], data[7:0]} (replicated to both lanes)
  - mem_be = 10 if addr[0] else 01
- Halfword store: mem_addr = addr, mem_wdata = data[15:0], mem_be = 11.
- Word store:
  - BEAT0: mem_addr = addr, mem_wdata = data[15:0], mem_be = 11.
  - BEAT1: mem_addr = addr + 2 (modulo 2^ADDR_W; wrap allowed, no error), mem_wdata = data[31:16], mem_be = 11.
- A beat completes on a rising edge with mem_valid && mem_ready.
- While mem_valid is high and mem_ready is low, mem_valid, mem_addr, mem_wdata and mem_be hold stable. mem_valid never drops without a handshake, except on reset.
- BEAT0 complete: byte/half store goes to IDLE; word store goes to BEAT1, with mem_valid staying high and the new beat presented the very next cycle (no bubble).
- BEAT1 complete: go to IDLE.
- done = 1 for exactly one cycle after the final beat handshake. This is the same cycle req_ready returns high, so a new request may be accepted while done is high. Back-to-back stores have one idle cycle of mem_valid between them.
- mem_ready while mem_valid = 0 is ignored.
- Reset mid-operation: the beat is abandoned, mem_valid drops asynchronously, no done; the partial word write is not undone.
- mem_be is never 00 while mem_valid = 1.

Test Plan:
- SB, addr 0x0000_1003, data 0xAABBCCDD, mem_ready tied 1 -> one beat: mem_addr 0x1002, wdata 0xDDDD, be 10; done pulses one cycle later; misaligned stays 0.
- SH, addr 0x0000_2002, data 0x1234_5678, mem_ready low 3 cycles then high -> mem_valid held 4 cycles with addr 0x2002, wdata 0x5678, be 11, all stable; exactly one done.
- SW, addr 0x0000_3000, data 0xCAFEBABE, mem_ready 1 -> consecutive beats (0x3000, 0xBABE, 11) then (0x3002, 0xCAFE, 11); done once; req_ready low for 2 cycles.
- SW at addr 0x0000_3002, then SH at 0x0000_0001, then size 11 -> three misaligned pulses, mem_valid never asserted, req_ready high throughout.
- SW at 0xFFFF_FFFC -> second beat address 0xFFFF_FFFE; SW at 0xFFFF_FFFE rejected as misaligned.
- SW with mem_ready low in BEAT1, rst asserted -> mem_valid low immediately; no done; after release req_ready = 1 and the next SB completes normally.
